sm4_result_unpacker: RTL and testbench

SM4_RESULT_UNPACKER -- requirements
Module: sm4_result_unpacker

---
 rtl/sm4_result_unpacker.sv | 132 +++++++++++++
 tb/tb_sm4_result_unpacker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sm4_result_unpacker.sv
// rtl/sm4_result_unpacker.sv - 128-bit SM4 result to 32-bit word stream unpacker with overflow flag
// Optional macro: SM4_RESULT_BYTE_SWAP_EN (byte-reverses every OUT_WORD for the RV32 load path).
module sm4_result_unpacker #(
    parameter int MSW_FIRST = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         save_data_i,
    input  logic [127:0] result_31_i,
    input  logic         out_ready_i,
    input  logic         clr_ovf_i,
    output logic         out_valid_o,
    output logic [31:0]  out_word_o,
    output logic [1:0]   word_idx_o,
    output logic         last_word_o,
    output logic         busy_o,
    output logic         overflow_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   buf_q, buf_d;
    logic [1:0]     idx_q, idx_d;
    logic           ovf_q, ovf_d;

    logic           xfer;
    logic           last_xfer;
    logic           ovf_set;
    logic [31:0]    slice;
    logic [31:0]    word_fmt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign xfer      = (state_q == SEND) && out_ready_i;
    assign last_xfer = xfer && (idx_q == 2'd3);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        ovf_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (save_data_i) begin
                    buf_d   = result_31_i;
                    idx_d   = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_xfer) begin
                    // A block arriving on the final transfer is chained in without a bubble.
                    idx_d = 2'd0;
                    if (save_data_i) begin
                        buf_d = result_31_i;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + 2'd1;
                    end
                    if (save_data_i) begin
                        ovf_set = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        slice = '0;
        if (MSW_FIRST != 0) begin
            case (idx_q)
                2'd0:    slice = buf_q[127:96];
                2'd1:    slice = buf_q[95:64];
                2'd2:    slice = buf_q[63:32];
                default: slice = buf_q[31:0];
            endcase
        end else begin
            case (idx_q)
                2'd0:    slice = buf_q[31:0];
                2'd1:    slice = buf_q[63:32];
                2'd2:    slice = buf_q[95:64];
                default: slice = buf_q[127:96];
            endcase
        end
    end

`ifdef SM4_RESULT_BYTE_SWAP_EN
    assign word_fmt = {slice[7:0], slice[15:8], slice[23:16], slice[31:24]};
`else
    assign word_fmt = slice;
`endif

    assign out_valid_o = (state_q == SEND);
    assign busy_o      = (state_q == SEND);
    assign out_word_o  = (state_q == SEND) ? word_fmt : 32'd0;
    assign word_idx_o  = idx_q;
    assign last_word_o = (state_q == SEND) && (idx_q == 2'd3);
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_sm4_result_unpacker.sv
// tb/tb_sm4_result_unpacker.sv - vector table, corner sequences and randomized model check
module tb_sm4_result_unpacker;

    localparam int MSW = 1;
    localparam logic [127:0] BLK_B = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_A = {4{32'hA5A5A5A5}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         save;
    logic [127:0] data;
    logic         ready;
    logic         clr;
    logic         valid;
    logic [31:0]  word;
    logic [1:0]   idx;
    logic         last;
    logic         busy;
    logic         ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sm4_result_unpacker #(.MSW_FIRST(MSW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .save_data_i(save), .result_31_i(data),
        .out_ready_i(ready), .clr_ovf_i(clr), .out_valid_o(valid), .out_word_o(word),
        .word_idx_o(idx), .last_word_o(last), .busy_o(busy), .overflow_o(ovf)
    );

    typedef struct {
        logic         save;
        logic         ready;
        logic         clr;
        logic [127:0] data;
        logic         valid;
        logic [31:0]  word;
        logic [1:0]   idx;
        logic         last;
        logic         busy;
        logic         ovf;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] fmt(input logic [31:0] w);
`ifdef SM4_RESULT_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic void add(input logic s, input logic r, input logic c, input logic [127:0] d,
                                input logic v, input logic [31:0] w, input logic [1:0] i,
                                input logic l, input logic b, input logic o);
        vec_t e;
        e.save = s; e.ready = r; e.clr = c; e.data = d;
        e.valid = v; e.word = w; e.idx = i; e.last = l; e.busy = b; e.ovf = o;
        vt.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [31:0] w, input logic [1:0] i,
                           input logic l, input logic b, input logic o);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
        chk({tag, ".word"},  word, w);
        chk({tag, ".idx"},   {30'd0, idx}, {30'd0, i});
        chk({tag, ".last"},  {31'd0, last}, {31'd0, l});
        chk({tag, ".busy"},  {31'd0, busy}, {31'd0, b});
        chk({tag, ".ovf"},   {31'd0, ovf}, {31'd0, o});
    endtask

    task automatic drive(input logic s, input logic r, input logic c, input logic [127:0] d);
        save = s; ready = r; clr = c; data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        save = 1'b0; ready = 1'b0; clr = 1'b0; data = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: block held as four words in transfer order plus a position.
    logic        m_busy;
    logic [31:0] m_words[4];
    int          m_k;
    logic        m_ovf;

    task automatic model_step(input logic s, input logic r, input logic c, input logic [127:0] d);
        logic done, accept, drop;
        done   = m_busy && r && (m_k == 3);
        accept = s && (!m_busy || done);
        drop   = s && !accept;
        if (m_busy && r) begin
            m_k = (m_k + 1) % 4;
            if (m_k == 0) m_busy = 1'b0;
        end
        if (accept) begin
            for (int j = 0; j < 4; j++)
                m_words[j] = 32'(d >> ((MSW != 0) ? (96 - 32 * j) : (32 * j)));
            m_k = 0;
            m_busy = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        do_reset();
        chk_all("reset", 1'b0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Streaming block, chained block on the last transfer, overflow, clear, set-beats-clear.
        add(1, 1, 0, BLK_B, 1, 32'h00112233, 0, 0, 1, 0);
        add(0, 1, 0, '0,    1, 32'h44556677, 1, 0, 1, 0);
        add(0, 1, 0, '0,    1, 32'h8899AABB, 2, 0, 1, 0);
        add(0, 1, 0, '0,    1, 32'hCCDDEEFF, 3, 1, 1, 0);
        add(1, 1, 0, BLK_A, 1, 32'hA5A5A5A5, 0, 0, 1, 0);
        add(0, 1, 0, '0,    1, 32'hA5A5A5A5, 1, 0, 1, 0);
        add(0, 1, 0, '0,    1, 32'hA5A5A5A5, 2, 0, 1, 0);
        add(0, 1, 0, '0,    1, 32'hA5A5A5A5, 3, 1, 1, 0);
        add(0, 1, 0, '0,    0, 32'h0,        0, 0, 0, 0);
        add(1, 1, 0, BLK_B, 1, 32'h00112233, 0, 0, 1, 0);
        add(0, 1, 0, '0,    1, 32'h44556677, 1, 0, 1, 0);
        add(1, 1, 0, BLK_A, 1, 32'h8899AABB, 2, 0, 1, 1);
        add(0, 1, 0, '0,    1, 32'hCCDDEEFF, 3, 1, 1, 1);
        add(0, 1, 0, '0,    0, 32'h0,        0, 0, 0, 1);
        add(0, 1, 1, '0,    0, 32'h0,        0, 0, 0, 0);
        add(1, 0, 0, BLK_B, 1, 32'h00112233, 0, 0, 1, 0);
        add(1, 0, 1, BLK_A, 1, 32'h00112233, 0, 0, 1, 1);
        add(0, 1, 1, '0,    1, 32'h44556677, 1, 0, 1, 0);
        add(0, 1, 0, '0,    1, 32'h8899AABB, 2, 0, 1, 0);
        add(0, 1, 0, '0,    1, 32'hCCDDEEFF, 3, 1, 1, 0);
        add(0, 1, 0, '0,    0, 32'h0,        0, 0, 0, 0);
        add(0, 1, 0, '0,    0, 32'h0,        0, 0, 0, 0);

        for (int n = 0; n < vt.size(); n++) begin
            drive(vt[n].save, vt[n].ready, vt[n].clr, vt[n].data);
            chk_all($sformatf("vec%0d", n), vt[n].valid, fmt(vt[n].word), vt[n].idx,
                    vt[n].last, vt[n].busy, vt[n].ovf);
        end

        // Back-pressure at word 1 for three cycles.
        drive(1, 1, 0, BLK_B);
        drive(0, 1, 0, '0);
        chk_all("stall.w1", 1, fmt(32'h44556677), 1, 0, 1, 0);
        for (int n = 0; n < 3; n++) begin
            drive(0, 0, 0, '0);
            chk_all($sformatf("stall.hold%0d", n), 1, fmt(32'h44556677), 1, 0, 1, 0);
        end
        drive(0, 1, 0, '0);
        chk_all("stall.w2", 1, fmt(32'h8899AABB), 2, 0, 1, 0);
        drive(0, 1, 0, '0);
        chk_all("stall.w3", 1, fmt(32'hCCDDEEFF), 3, 1, 1, 0);
        drive(0, 1, 0, '0);
        chk_all("stall.idle", 0, 32'd0, 0, 0, 0, 0);

        // Asynchronous reset at word 2, then capture on the first edge after release.
        drive(1, 1, 0, BLK_B);
        drive(0, 1, 0, '0);
        drive(0, 1, 0, '0);
        chk_all("rst.pre", 1, fmt(32'h8899AABB), 2, 0, 1, 0);
        save = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all("rst.async", 0, 32'd0, 0, 0, 0, 0);
        #3;
        rst_n = 1'b1;
        drive(1, 1, 0, BLK_A);
        chk_all("rst.after", 1, fmt(32'hA5A5A5A5), 0, 0, 1, 0);
        drive(0, 1, 0, '0);
        chk_all("rst.after1", 1, fmt(32'hA5A5A5A5), 1, 0, 1, 0);

        // Randomized traffic against the reference model.
        do_reset();
        m_busy = 1'b0; m_k = 0; m_ovf = 1'b0;
        for (int j = 0; j < 4; j++) m_words[j] = '0;
        for (int n = 0; n < 600; n++) begin
            logic s, r, c;
            logic [127:0] d;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 15) == 0);
            d = {$urandom, $urandom, $urandom, $urandom};
            model_step(s, r, c, d);
            drive(s, r, c, d);
            chk_all($sformatf("rnd%0d", n), m_busy, m_busy ? fmt(m_words[m_k]) : 32'd0,
                    2'(m_k), m_busy && (m_k == 3), m_busy, m_ovf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
